// File: rtl/product_unpack_fifo_pkg.sv
// Shared product-word definitions used by the unpack FIFO and the product register.
// The packed layout puts y in the upper nibble and x in the lower byte.
package product_unpack_fifo_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 4;
  localparam int P_W = X_W + Y_W;

  localparam logic [X_W-1:0] INIT_X_DEF = 8'hde;
  localparam logic [Y_W-1:0] INIT_Y_DEF = 4'ha;

  typedef struct packed {
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } product_t;

  // The cast is the whole unpack: fields fall out of the bit positions.
  function automatic product_t unpack_word(logic [P_W-1:0] word);
    return product_t'(word);
  endfunction

endpackage

// File: rtl/product_unpack_fifo_if.sv
// Producer/consumer bundle for the product unpack FIFO.
// The slave side is the FIFO; the master side is whoever drives it.
interface product_unpack_fifo_if
  import product_unpack_fifo_pkg::*;
#(
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [P_W-1:0] I;
  logic           I_valid;
  logic           I_ready;
  logic [X_W-1:0] O_x;
  logic [Y_W-1:0] O_y;
  logic           O_valid;
  logic           O_ready;
  logic [CW-1:0]  COUNT;

  modport slave (
    input  I, I_valid, O_ready,
    output I_ready, O_x, O_y, O_valid, COUNT
  );

  modport master (
    output I, I_valid, O_ready,
    input  I_ready, O_x, O_y, O_valid, COUNT
  );

endinterface

// File: rtl/fifo_mem_p12.sv
// DEPTH x 12 storage: one synchronous write port, one asynchronous read port.
module fifo_mem_p12
  import product_unpack_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  product_t      wdata,
  input  logic [AW-1:0] raddr,
  output product_t      rdata
);

  product_t mem [DEPTH];

  // NOTE: storage has no reset; occupancy lives in the controller, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/product_unpack_fifo.sv
// FIFO of packed product words that presents the head entry split into x/y fields.
// When empty, the outputs hold the last popped entry (or the init values after reset).
module product_unpack_fifo
  import product_unpack_fifo_pkg::*;
#(
  parameter int             DEPTH  = 4,
  parameter logic [X_W-1:0] INIT_X = INIT_X_DEF,
  parameter logic [Y_W-1:0] INIT_Y = INIT_Y_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  product_unpack_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          in_ready;
  logic          out_valid;
  product_t      hold;
  product_t      head;
  product_t      rdata;
  logic          push;
  logic          pop;

  // Reset wins over any handshake on the same edge, including the storage write.
  assign push = bus.I_valid && in_ready && !RESET;
  assign pop  = out_valid && bus.O_ready && !RESET;

  fifo_mem_p12 #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wptr),
    .wdata (unpack_word(bus.I)),
    .raddr (rptr),
    .rdata (rdata)
  );

  assign head = rdata;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Flags are computed from the next occupancy so they are registered yet exact.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      hold      <= '{y: INIT_Y, x: INIT_X};
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr <= rptr + AW'(1);
        hold <= head;
      end
      count     <= count_next;
      in_ready  <= (count_next < CW'(DEPTH));
      out_valid <= (count_next != '0);
    end
  end

  assign bus.O_x     = out_valid ? head.x : hold.x;
  assign bus.O_y     = out_valid ? head.y : hold.y;
  assign bus.O_valid = out_valid;
  assign bus.I_ready = in_ready;
  assign bus.COUNT   = count;

endmodule

// File: tb/tb_product_unpack_fifo.sv
// Directed bench for product_unpack_fifo: stimulus queues hand-computed x/y pairs,
// a negedge monitor pops and compares them whenever a pop handshake is presented.
module tb_product_unpack_fifo;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] x;
    logic [3:0] y;
  } exp_t;

  logic real_clk = 1'b0;
  logic RESET    = 1'b1;
  int   total    = 0;
  int   bad      = 0;
  exp_t exp_q[$];

  product_unpack_fifo_if #(.DEPTH(DEPTH)) bus ();

  product_unpack_fifo #(.DEPTH(DEPTH)) dut (
    .CLK   (real_clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 real_clk = ~real_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge real_clk);
    #1;
  endtask

  // Drives one word that the caller knows will be accepted on the next edge.
  task automatic push_word(input logic [11:0] w, input logic [7:0] ex, input logic [3:0] ey);
    bus.I       = w;
    bus.I_valid = 1'b1;
    exp_q.push_back('{x: ex, y: ey});
  endtask

  task automatic idle_inputs();
    bus.I_valid = 1'b0;
    bus.O_ready = 1'b0;
  endtask

  // Monitor: a pop happens on the coming edge when O_valid && O_ready outside reset.
  always @(negedge real_clk) begin
    if (!RESET && bus.O_valid === 1'b1 && bus.O_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got x=%0h y=%0h expected no entry", bus.O_x, bus.O_y);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_x", 32'(bus.O_x), 32'(e.x));
        check("pop_y", 32'(bus.O_y), 32'(e.y));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.I = 12'h000;
    idle_inputs();

    // Reset then idle
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    tick();
    check("rst_x",       32'(bus.O_x),     32'h de);
    check("rst_y",       32'(bus.O_y),     32'h a);
    check("rst_valid",   32'(bus.O_valid), 32'h0);
    check("rst_ready",   32'(bus.I_ready), 32'h1);
    check("rst_count",   32'(bus.COUNT),   32'h0);

    // Single push, visible one cycle later
    push_word(12'h5a3, 8'ha3, 4'h5);
    tick();
    bus.I_valid = 1'b0;
    check("one_x",       32'(bus.O_x),     32'h a3);
    check("one_y",       32'(bus.O_y),     32'h5);
    check("one_valid",   32'(bus.O_valid), 32'h1);
    check("one_count",   32'(bus.COUNT),   32'h1);
    bus.O_ready = 1'b1;
    tick();
    bus.O_ready = 1'b0;
    check("one_empty",   32'(bus.COUNT),   32'h0);

    // Fill to full; a fifth push is ignored
    push_word(12'h001, 8'h01, 4'h0); tick();
    push_word(12'h002, 8'h02, 4'h0); tick();
    push_word(12'h003, 8'h03, 4'h0); tick();
    push_word(12'h004, 8'h04, 4'h0); tick();
    check("full_count",  32'(bus.COUNT),   32'h4);
    check("full_ready",  32'(bus.I_ready), 32'h0);
    bus.I = 12'h005;
    tick(); tick();
    bus.I_valid = 1'b0;
    check("ign_count",   32'(bus.COUNT),   32'h4);
    check("ign_x",       32'(bus.O_x),     32'h01);
    bus.O_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.O_ready = 1'b0;
    check("drain_count", 32'(bus.COUNT),   32'h0);
    check("drain_hold",  32'(bus.O_x),     32'h04);

    // Full, one pop, then 8 cycles of simultaneous push/pop across the wrap
    push_word(12'h011, 8'h11, 4'h0); tick();
    push_word(12'h012, 8'h12, 4'h0); tick();
    push_word(12'h013, 8'h13, 4'h0); tick();
    push_word(12'h014, 8'h14, 4'h0); tick();
    bus.I_valid = 1'b0;
    bus.O_ready = 1'b1;
    tick();
    bus.O_ready = 1'b0;
    check("pop1_count",  32'(bus.COUNT),   32'h3);
    check("pop1_ready",  32'(bus.I_ready), 32'h1);
    bus.O_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [11:0] w;
      w = 12'h021 + 12'(i);
      push_word(w, w[7:0], 4'h0);
      tick();
      check("pp_count",  32'(bus.COUNT),   32'h3);
    end
    bus.I_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.O_ready = 1'b0;
    check("pp_empty",    32'(bus.COUNT),   32'h0);

    // Hold of the last popped entry while empty
    push_word(12'hfff, 8'hff, 4'hf);
    tick();
    bus.I_valid = 1'b0;
    bus.O_ready = 1'b1;
    tick();
    bus.O_ready = 1'b0;
    tick(); tick();
    check("hold_valid",  32'(bus.O_valid), 32'h0);
    check("hold_x",      32'(bus.O_x),     32'h ff);
    check("hold_y",      32'(bus.O_y),     32'h f);

    // Reset with pending entries and both handshakes asserted
    push_word(12'h031, 8'h31, 4'h0); tick();
    push_word(12'h032, 8'h32, 4'h0); tick();
    bus.I       = 12'h033;
    bus.I_valid = 1'b1;
    bus.O_ready = 1'b1;
    RESET       = 1'b1;
    exp_q.delete();
    tick();
    RESET = 1'b0;
    idle_inputs();
    check("mrst_count",  32'(bus.COUNT),   32'h0);
    check("mrst_x",      32'(bus.O_x),     32'h de);
    check("mrst_y",      32'(bus.O_y),     32'h a);
    check("mrst_valid",  32'(bus.O_valid), 32'h0);
    check("mrst_ready",  32'(bus.I_ready), 32'h1);
    tick();
    check("mrst_still",  32'(bus.COUNT),   32'h0);
    check("sb_empty",    32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/product_unpack_fifo.md
PRODUCT_UNPACK_FIFO -- requirements
Module: product_unpack_fifo

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set entry count; legal values are powers of two, 2 to 16.
REQ-002 Parameter INIT_X, default 8'hde, SHALL be the reset and empty-hold value of O_x.
REQ-003 Parameter INIT_Y, default 4'ha, SHALL be the reset and empty-hold value of O_y.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 RESET  input  1  SHALL be the reset; synchronous, active-high.
REQ-006 I  input  12  SHALL carry the packed product word; y in bits [11:8], x in bits [7:0].
REQ-007 I_valid  input  1  SHALL mark I as valid this cycle.
REQ-008 I_ready  output  1  SHALL indicate the block can accept a word this cycle.
REQ-009 O_x  output  8  SHALL carry the x field of the head entry.
REQ-010 O_y  output  4  SHALL carry the y field of the head entry.
REQ-011 O_valid  output  1  SHALL indicate that O_x/O_y hold a valid head entry.
REQ-012 O_ready  input  1  SHALL indicate that the consumer takes the head entry this cycle.
REQ-013 COUNT  output  $clog2(DEPTH)+1  SHALL give the current occupancy.

Function
REQ-014 A push SHALL occur on an edge where I_valid and I_ready are both 1; a pop SHALL occur on an edge where O_valid and O_ready are both 1.
REQ-015 I_ready SHALL be 1 exactly when COUNT < DEPTH; it is registered and does not depend combinationally on O_ready (no pass-through when full).
REQ-016 O_valid SHALL be 1 exactly when COUNT > 0.
REQ-017 Latency: a word pushed at edge n SHALL be visible on O_x/O_y with O_valid=1 from cycle n+1, when the FIFO was empty before the push.
REQ-018 Unpacking SHALL be pure bit-slicing: O_x = I[7:0] and O_y = I[11:8] of the stored word, with no reordering.
REQ-019 Order SHALL be strict FIFO.
REQ-020 When empty, O_x/O_y SHALL hold the fields of the last popped entry, or INIT_X/INIT_Y if nothing has been popped since reset.
REQ-021 Simultaneous push and pop with 0 < COUNT < DEPTH SHALL leave COUNT unchanged.
REQ-022 When full, a push SHALL be impossible (I_ready=0); a pop in that cycle SHALL reduce COUNT to DEPTH-1, and I_ready SHALL rise on the next cycle.
REQ-023 When empty, a pop SHALL be impossible; a same-cycle push SHALL give COUNT=1.
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH without extra logic.
REQ-025 I_valid asserted while I_ready=0 SHALL be ignored, and the producer SHALL hold I stable until accepted.

Reset
REQ-026 On an edge with RESET=1, the block SHALL apply COUNT=0, both pointers 0, O_valid=0, I_ready=1, O_x=INIT_X and O_y=INIT_Y, regardless of I_valid/O_ready.
REQ-027 Reset mid-operation SHALL discard all stored entries; storage contents need not be cleared.
REQ-028 No push or pop SHALL occur on an edge where RESET=1.

Structure
REQ-029 A shared package SHALL hold X_W=8, Y_W=4, P_W=12, the default INIT_X/INIT_Y values, and the packed product typedef {y,x} used by both this block and the product register.
REQ-030 Storage SHALL be a sub-module fifo_mem_p12: DEPTH x 12 with one synchronous write port and one asynchronous read port.
REQ-031 Control (pointers, COUNT, flags, hold register for O_x/O_y) SHALL reside in product_unpack_fifo.

Verification
REQ-032 Reset then idle -> O_x=8'hde, O_y=4'ha, O_valid=0, I_ready=1, COUNT=0.
REQ-033 Push 12'h5a3 with O_ready=0 -> next cycle O_x=8'ha3, O_y=4'h5, O_valid=1, COUNT=1.
REQ-034 Push 12'h001, 12'h002, 12'h003, 12'h004 with O_ready=0 -> COUNT=4, I_ready=0; a fifth push is ignored; draining returns O_x 01, 02, 03, 04 in order.
REQ-035 With the FIFO full, assert O_ready for one cycle -> COUNT=3 and I_ready=1 the next cycle; then push and pop together for 8 cycles -> COUNT stays 3, pointers wrap, and order is preserved.
REQ-036 Push 12'hfff then pop -> while empty, O_x=8'hff and O_y=4'hf are held with O_valid=0.
REQ-037 Fill 2 entries, assert RESET with I_valid=1 and O_ready=1 -> COUNT=0, O_x=8'hde, O_y=4'ha, and no entry is popped or pushed.
